// File: rtl/cordic_pkg.sv
// cordic_pkg: constants and types shared by the CORDIC float unpacker and
// float packer.
//   FP_EXP_W / FP_MANT_W / FP_BIAS : IEEE-754 single-precision field layout
//   FP_ZERO                        : +0.0 encoding
//   ieee_sp_t                      : packed {sign, exp, mant} view of a float
package cordic_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;
    localparam int FP_BIAS   = 127;
    localparam logic [31:0] FP_ZERO = 32'h0;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
    } ieee_sp_t;

endpackage

// File: rtl/float_packer_if.sv
// float_packer_if: valid/ready streams into and out of the float packer.
//   in_valid / in_ready / in_data    : fixed-point input stream
//   out_valid / out_ready / out_data : IEEE-754 single output stream
//   slave  : the packer's view
//   master : the view of whatever drives the input and drains the output
interface float_packer_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/lzc32.sv
// lzc32: combinational leading-one position encoder.
//   a    : 32-bit input word
//   p    : bit index of the most significant set bit (0 when a == 0)
//   zero : a == 0
module lzc32 (
    input  logic [31:0] a,
    output logic [4:0]  p,
    output logic        zero
);

    // Ascending scan, so the highest set bit is the last one written.
    always_comb begin
        p = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (a[i]) p = 5'(i);
        end
    end

    assign zero = ~|a;

endmodule

// File: rtl/float_packer.sv
// float_packer: signed fixed-point (FRAC_BITS fractional bits) to IEEE-754
// single precision. Three-stage pipeline, one conversion per cycle, with a
// global stall when the output is held by the consumer.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset; flushes every in-flight item
//   bus     : float_packer_if.slave (input and output valid/ready streams)
// Build option: define PACKER_ROUND_NEAREST_EN for round-to-nearest-even;
// otherwise the magnitude is truncated toward zero.
module float_packer
    import cordic_pkg::*;
#(
    parameter int FRAC_BITS = 30
) (
    input  logic          clk,
    input  logic          reset_n,
    float_packer_if.slave bus
);

    localparam int STAGES = 3;

    logic [STAGES:1] vld_pipe;
    logic            stall;
    logic            adv;

    // Stage 1 state: sign / magnitude / zero.
    logic        s1_sign;
    logic        s1_zero;
    logic [31:0] s1_mag;

    // Stage 2 state: normalized magnitude and pre-rounding exponent.
    logic        s2_sign;
    logic        s2_zero;
    logic [31:0] s2_norm;
    logic [7:0]  s2_exp;

    ieee_sp_t    out_q;

    // Whole pipe freezes together while the consumer holds the output.
    assign stall        = vld_pipe[STAGES] & ~bus.out_ready;
    assign adv          = ~stall;
    assign bus.in_ready = ~stall;
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.out_data  = out_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vld_pipe <= '0;
        else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
    end

    // ---------------- stage 1 ----------------
    // Negation in 32-bit unsigned gives 2^31 for 32'h80000000, as wanted.
    logic [31:0] mag_c;
    assign mag_c = bus.in_data[31] ? (~bus.in_data + 32'd1) : bus.in_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_sign <= 1'b0;
            s1_zero <= 1'b0;
            s1_mag  <= '0;
        end else if (adv) begin
            s1_sign <= bus.in_data[31];
            s1_zero <= (bus.in_data == 32'd0);
            s1_mag  <= mag_c;
        end
    end

    // ---------------- stage 2 ----------------
    logic [4:0]  lead_p;
    logic        lzc_zero_unused;
    logic [31:0] norm_c;
    logic [7:0]  exp_pre_c;

    lzc32 u_lzc (
        .a    (s1_mag),
        .p    (lead_p),
        .zero (lzc_zero_unused)
    );

    assign norm_c    = s1_mag << (5'd31 - lead_p);
    // 127 + p - FRAC_BITS stays within 96..158 for every legal FRAC_BITS.
    assign exp_pre_c = 8'(FP_BIAS + int'(lead_p) - FRAC_BITS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_sign <= 1'b0;
            s2_zero <= 1'b0;
            s2_norm <= '0;
            s2_exp  <= '0;
        end else if (adv) begin
            s2_sign <= s1_sign;
            s2_zero <= s1_zero;
            s2_norm <= norm_c;
            s2_exp  <= exp_pre_c;
        end
    end

    // ---------------- stage 3 ----------------
    logic [FP_MANT_W-1:0] mant_c;
    logic [FP_EXP_W-1:0]  exp_c;
    ieee_sp_t             res_c;

`ifdef PACKER_ROUND_NEAREST_EN
    logic        guard_c;
    logic        sticky_c;
    logic        rnd_up_c;
    logic [23:0] mant_sum_c;

    assign guard_c    = s2_norm[7];
    assign sticky_c   = |s2_norm[6:0];
    assign rnd_up_c   = guard_c & (sticky_c | s2_norm[8]);
    assign mant_sum_c = {1'b0, s2_norm[30:8]} + {23'd0, rnd_up_c};

    // A carry out of the mantissa leaves all 23 low sum bits zero, so only
    // the exponent needs adjusting.
    always_comb begin
        mant_c = mant_sum_c[22:0];
        exp_c  = s2_exp;
        if (mant_sum_c[23]) exp_c = s2_exp + 8'd1;
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, s2_norm[31], lzc_zero_unused};
`else
    always_comb begin
        mant_c = s2_norm[30:8];
        exp_c  = s2_exp;
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, s2_norm[31], s2_norm[7:0], lzc_zero_unused};
`endif

    // Zero never carries the input sign: always +0.
    always_comb begin
        res_c = ieee_sp_t'({s2_sign, exp_c, mant_c});
        if (s2_zero) res_c = ieee_sp_t'(FP_ZERO);
    end

    // Bubbles leave the last result in place; out_valid says whether it counts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                  out_q <= ieee_sp_t'(FP_ZERO);
        else if (adv && vld_pipe[2])   out_q <= res_c;
    end

endmodule

// File: tb/tb_float_packer.sv
// tb_float_packer: directed-vector bench for float_packer (FRAC_BITS = 30).
// Covers reset state, exact latency on a back-to-back stream, sign, zero,
// minimum negative, rounding/truncation boundaries, backpressure ordering and
// stability, and a reset pulse with items in flight.
module tb_float_packer;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    float_packer_if bus ();

    float_packer #(.FRAC_BITS(30)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    // Directed vectors, shared by the streaming runs.
    logic [31:0] vin  [10];
    logic [31:0] vexp [10];

    // Present vin[0..n-1] back-to-back with out_ready high; vin[c] must
    // appear on the output exactly after the third edge counted from the
    // edge that accepted it (edge c+2 in this loop), never earlier.
    task automatic run_stream(input int n, input string tag);
        for (int c = 0; c < n + 3; c++) begin
            if (c < n) begin
                bus.in_valid = 1'b1;
                bus.in_data  = vin[c];
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = 32'h0;
            end
            @(posedge clk); #1;
            if (c >= 2 && c - 2 < n) begin
                chk($sformatf("%s_vld%0d", tag, c - 2), 32'(bus.out_valid), 32'd1);
                chk($sformatf("%s_dat%0d", tag, c - 2), bus.out_data, vexp[c - 2]);
            end else begin
                chk($sformatf("%s_idle%0d", tag, c), 32'(bus.out_valid), 32'd0);
            end
        end
    endtask

    initial begin
        logic [31:0] held;
        logic        prev_stall;
        int          sent;
        int          rcv;
        logic        fire_in;
        logic        fire_out;
        logic [31:0] snap;

        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  bus.out_data,       32'h0);
        reset_n = 1'b1;
        #1;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk); #1;

        // ---- basic conversions and boundaries ----
        vin[0] = 32'h40000000; vexp[0] = 32'h3F800000;  //  1.0
        vin[1] = 32'hC0000000; vexp[1] = 32'hBF800000;  // -1.0
        vin[2] = 32'h20000000; vexp[2] = 32'h3F000000;  //  0.5
        vin[3] = 32'h00000001; vexp[3] = 32'h30800000;  //  2^-30
        vin[4] = 32'h00000000; vexp[4] = 32'h00000000;  //  +0
        vin[5] = 32'h80000000; vexp[5] = 32'hC0000000;  // -2.0
        vin[6] = 32'hFFFFFFFF; vexp[6] = 32'hB0800000;  // -2^-30
`ifdef PACKER_ROUND_NEAREST_EN
        vin[7] = 32'h01FFFFFF; vexp[7] = 32'h3D000000;  // tie, odd -> carry
        vin[8] = 32'h7FFFFFFF; vexp[8] = 32'h40000000;  // round up to 2.0
`else
        vin[7] = 32'h01FFFFFF; vexp[7] = 32'h3CFFFFFF;  // truncated
        vin[8] = 32'h7FFFFFFF; vexp[8] = 32'h3FFFFFFF;  // truncated
`endif
        run_stream(9, "basic");

        // ---- backpressure: out_ready low for cycles 4..8 ----
        vin[0] = 32'h40000000; vexp[0] = 32'h3F800000;
        vin[1] = 32'hC0000000; vexp[1] = 32'hBF800000;
        vin[2] = 32'h20000000; vexp[2] = 32'h3F000000;
        vin[3] = 32'h00000001; vexp[3] = 32'h30800000;
        vin[4] = 32'h80000000; vexp[4] = 32'hC0000000;
        sent = 0;
        rcv = 0;
        prev_stall = 1'b0;
        held = 32'h0;
        for (int c = 0; c < 30; c++) begin
            bus.out_ready = !(c >= 4 && c <= 8);
            if (sent < 5) begin
                bus.in_valid = 1'b1;
                bus.in_data  = vin[sent];
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = 32'h0;
            end
            #1;
            if (c >= 4 && c <= 8) begin
                chk($sformatf("bp_in_ready_c%0d", c),  32'(bus.in_ready),  32'd0);
                chk($sformatf("bp_out_valid_c%0d", c), 32'(bus.out_valid), 32'd1);
            end
            if (prev_stall)
                chk($sformatf("bp_stable_c%0d", c), bus.out_data, held);
            prev_stall = bus.out_valid && !bus.out_ready;
            held       = bus.out_data;
            fire_in    = bus.in_valid && bus.in_ready;
            fire_out   = bus.out_valid && bus.out_ready;
            snap       = bus.out_data;
            @(posedge clk); #1;
            if (fire_in) sent++;
            if (fire_out) begin
                if (rcv < 5) chk($sformatf("bp_res%0d", rcv), snap, vexp[rcv]);
                else         chk("bp_extra_output", snap, 32'hxxxxxxxx);
                rcv++;
            end
        end
        chk("bp_sent_count", 32'(sent), 32'd5);
        chk("bp_recv_count", 32'(rcv),  32'd5);
        bus.out_ready = 1'b1;

        // ---- reset with items in flight ----
        bus.in_valid = 1'b1; bus.in_data = 32'h40000000; @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_data = 32'h20000000; @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_data = 32'hC0000000; @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_data = 32'h0;
        chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        chk("pre_rst_out_data",  bus.out_data,       32'h3F800000);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_out_data",  bus.out_data,       32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk($sformatf("post_rst_idle%0d", c), 32'(bus.out_valid), 32'd0);
        end
        vin[0] = 32'hE0000000; vexp[0] = 32'hBF000000;  // -0.5
        run_stream(1, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
